ddr_button_conditioner: RTL and testbench
=========================================

# ddr_button_conditioner

Input-side conditioner for the DDR game: takes the four raw, asynchronous, bouncing push-buttons (up, down, left, right), synchronizes and debounces them, and turns each clean press into a one-cycle pulse and a buffered press event. The buffered event is held under a valid/ack handshake so the hit-detection logic consumes exactly one press per arrow window. Sits between the board buttons and the collision/scoring path, in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronized input must differ from the debounced level before the level flips (5 ms at 100 MHz); minimum 2.
- `CNT_BITS`, 19: width of each debounce counter; must hold `DEBOUNCE_CYCLES-1`.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `btn_raw` in 4: raw buttons, bit3=U, bit2=D, bit1=L, bit0=R; asynchronous, active-high.
- `enable` in 1: high while the game state is PLAY; gates event generation.
- `press_ack` in 1: consumer accepts the pending event.
- `btn_level` out 4: debounced button levels.
- `press_pulse` out 4: one-cycle pulse per debounced rising edge, gated by `enable`.
- `press_valid` out 1: a press event is pending.
- `press_vec` out 4: buttons of the pending event; more than one bit set means a chord.
- `overflow` out 1: one-cycle pulse when a press is dropped because an event is already pending.

## Operation
- Synchronizer: a 2-flop chain per bit, `btn_raw` -> `s1` -> `s2`.
- Debounce, per bit, independently:
  - If `s2 == btn_level`, the counter is cleared to 0.
  - Otherwise the counter increments. When it equals `DEBOUNCE_CYCLES-1` and `s2` still differs, `btn_level <= s2` and the counter clears.
  - Any single-cycle return to equality restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `btn_level`.
- Rising detect: `rise[i]` is true in the cycle where bit i's `btn_level` is about to flip 0->1.
  - `press_pulse <= rise & {4{enable}}`, registered on the same edge as the level flip.
  - Falling edges produce no pulse and no event.
- Event buffer, evaluated at each clock edge with `p = rise & {4{enable}}`, in priority order:
  1. `enable` low: `press_valid <= 0`, `press_vec <= 0`, `overflow <= 0`.
  2. `p != 0` and (`!press_valid` or `press_ack`): `press_valid <= 1`, `press_vec <= p`. The new event replaces the acked one with no gap cycle.
  3. `p != 0`, `press_valid`, `!press_ack`: `press_vec` is unchanged and `overflow <= 1` for one cycle.
  4. `p == 0` and `press_valid && press_ack`: `press_valid <= 0`, `press_vec <= 0`.
  5. Otherwise: hold.
- `press_ack` while `!press_valid` is ignored.
- Simultaneous rises on several bits in one cycle form a single event with multiple bits set.
- Bits whose rises are separated by one or more cycles form separate events; later ones are subject to overflow.
- Debouncing and `btn_level` run regardless of `enable`. A button held across `enable` 0->1 generates no event until it is released and pressed again.

## Timing
- Reset values: `btn_level=0`, `press_pulse=0`, `press_valid=0`, `press_vec=0`, `overflow=0`, all counters 0, synchronizers 0.
- Reset asserted mid-count or with an event pending clears everything immediately. The pending event is lost and no pulse is emitted on release.
- Latency: a raw edge captured into `s1` at edge E0 reaches `s2` at E1. The counter runs over edges E2 .. E(DEBOUNCE_CYCLES+1).
  - `btn_level`, `press_pulse` and `press_valid` change after edge E(DEBOUNCE_CYCLES+1).
  - This is `DEBOUNCE_CYCLES+2` edges after the raw change.
- `press_pulse` and `overflow` are high for exactly one cycle per event.
- `press_valid` falls the cycle after the ack edge, unless it is reloaded on that edge.
- Consumer contract: `press_vec` is stable whenever `press_valid` is high and no ack has been taken.

## Test plan
- Clean press, `DEBOUNCE_CYCLES=4`, `enable=1`: `btn_raw=4'b1000` held 20 cycles. Expected: `btn_level[3]` and `press_pulse=4'b1000` (one cycle) and `press_valid=1`, `press_vec=4'b1000`, all after the 6th edge. Valid stays high until `press_ack`, then clears one cycle later.
- Bounce: `btn_raw[1]` toggles 1,0,1,0 each 2 cycles, then held 1. Expected: exactly one `press_pulse=4'b0010`, 6 edges after the final 0->1. `btn_level[1]` does not change during the toggling.
- Chord versus stagger:
  - `btn_raw=4'b0101` in the same cycle: one event, `press_vec=4'b0101`.
  - R then U three cycles later, no ack: `press_vec=4'b0001` and one `overflow` pulse.
- Ack with simultaneous press: event pending for D, `press_ack=1` on the edge where a rise on L occurs. Expected: `press_valid` stays 1 and `press_vec` becomes `4'b0010` with no gap; `overflow=0`.
- Enable gating: button held while `enable=0`, then `enable=1`. Expected: no pulse and no event. Release and re-press then produces an event. Dropping `enable` while an event is pending clears `press_valid` on the next edge.
- Async reset mid-operation: assert `reset` between edges while the counter is at 2 and an event is pending. Expected: all outputs 0 immediately, without waiting for a clock edge. After deassert, a still-held button needs the full 6 edges to reappear.

Source files
------------

// File: rtl/ddr_button_conditioner.sv
// Button front end for the DDR game. Four raw buttons are synchronized and debounced,
// and each clean rising edge becomes a one-cycle pulse plus a buffered press event.
module ddr_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       enable,
    input  logic       press_ack,
    output logic [3:0] btn_level,
    output logic [3:0] press_pulse,
    output logic       press_valid,
    output logic [3:0] press_vec,
    output logic       overflow
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          s1;
    logic [3:0]          s2;
    logic [CNT_BITS-1:0] cnt [4];
    logic [3:0]          rise;
    logic [3:0]          p;

    // A rise is the cycle in which a low debounced level is about to flip high.
    always_comb begin
        rise = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rise[i] = s2[i] && !btn_level[i] && (cnt[i] == CNT_LAST);
        end
        p = rise & {4{enable}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Counters restart whenever the synchronized input agrees with the level again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Handshake: an event is transferred on an edge where press_valid && press_ack;
    // press_vec holds while press_valid is high and no ack has been taken, and a new
    // press on the ack edge reloads the buffer with no idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_pulse <= 4'b0000;
            press_valid <= 1'b0;
            press_vec   <= 4'b0000;
            overflow    <= 1'b0;
        end else begin
            press_pulse <= p;
            overflow    <= 1'b0;
            if (!enable) begin
                press_valid <= 1'b0;
                press_vec   <= 4'b0000;
            end else if (p != 4'b0000) begin
                if (!press_valid || press_ack) begin
                    press_valid <= 1'b1;
                    press_vec   <= p;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (press_valid && press_ack) begin
                press_valid <= 1'b0;
                press_vec   <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_ddr_button_conditioner.sv
// Directed bench for ddr_button_conditioner with DEBOUNCE_CYCLES=4: pulses are
// matched against an expected queue, buffer/handshake state is checked at fixed points.
module tb_ddr_button_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic       enable;
    logic       press_ack;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic       press_valid;
    logic [3:0] press_vec;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    ddr_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .enable(enable),
        .press_ack(press_ack),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .press_valid(press_valid),
        .press_vec(press_vec),
        .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_once();
        press_ack = 1'b1;
        tick(1);
        press_ack = 1'b0;
    endtask

    task automatic release_all();
        btn_raw = 4'b0000;
        tick(8);
    endtask

    // scoreboard: every nonzero pulse must match the next expected press
    always @(negedge clk) begin
        if (press_pulse !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL pulse_unexpected observed=%0h expected=none", press_pulse);
            end else begin
                chk("pulse", {4'b0, press_pulse}, {4'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_raw   = 4'b0000;
        enable    = 1'b1;
        press_ack = 1'b0;
        tick(2);
        chk("rst_level", {4'b0, btn_level}, 8'h0);
        chk("rst_valid", {7'b0, press_valid}, 8'h0);
        chk("rst_vec", {4'b0, press_vec}, 8'h0);
        chk("rst_ovf", {7'b0, overflow}, 8'h0);
        reset = 1'b0;
        tick(1);

        // clean press on U
        btn_raw = 4'b1000;
        exp_q.push_back(4'b1000);
        tick(5);
        chk("clean_level_early", {4'b0, btn_level}, 8'h0);
        chk("clean_valid_early", {7'b0, press_valid}, 8'h0);
        tick(1);
        chk("clean_level", {4'b0, btn_level}, 8'h8);
        chk("clean_pulse", {4'b0, press_pulse}, 8'h8);
        chk("clean_valid", {7'b0, press_valid}, 8'h1);
        chk("clean_vec", {4'b0, press_vec}, 8'h8);
        tick(1);
        chk("clean_pulse_drop", {4'b0, press_pulse}, 8'h0);
        chk("clean_valid_hold", {7'b0, press_valid}, 8'h1);
        ack_once();
        chk("clean_valid_acked", {7'b0, press_valid}, 8'h0);
        chk("clean_vec_acked", {4'b0, press_vec}, 8'h0);
        release_all();
        chk("clean_release", {4'b0, btn_level}, 8'h0);

        // bounce on L
        for (int i = 0; i < 2; i++) begin
            btn_raw = 4'b0010;
            tick(2);
            btn_raw = 4'b0000;
            tick(2);
            chk("bounce_level_steady", {4'b0, btn_level}, 8'h0);
        end
        btn_raw = 4'b0010;
        exp_q.push_back(4'b0010);
        tick(5);
        chk("bounce_level_early", {4'b0, btn_level}, 8'h0);
        tick(1);
        chk("bounce_level", {4'b0, btn_level}, 8'h2);
        chk("bounce_vec", {4'b0, press_vec}, 8'h2);
        ack_once();
        release_all();

        // chord
        btn_raw = 4'b0101;
        exp_q.push_back(4'b0101);
        tick(6);
        chk("chord_valid", {7'b0, press_valid}, 8'h1);
        chk("chord_vec", {4'b0, press_vec}, 8'h5);
        ack_once();
        release_all();

        // stagger: R, then U three cycles later without ack
        btn_raw = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(3);
        btn_raw = 4'b1001;
        exp_q.push_back(4'b1000);
        tick(3);
        chk("stagger_vec_r", {4'b0, press_vec}, 8'h1);
        chk("stagger_ovf_quiet", {7'b0, overflow}, 8'h0);
        tick(3);
        chk("stagger_ovf", {7'b0, overflow}, 8'h1);
        chk("stagger_vec_kept", {4'b0, press_vec}, 8'h1);
        tick(1);
        chk("stagger_ovf_drop", {7'b0, overflow}, 8'h0);
        ack_once();
        release_all();

        // ack on the same edge as a new rise
        btn_raw = 4'b0100;
        exp_q.push_back(4'b0100);
        tick(6);
        chk("ackrise_vec_d", {4'b0, press_vec}, 8'h4);
        btn_raw = 4'b0110;
        exp_q.push_back(4'b0010);
        tick(5);
        press_ack = 1'b1;
        tick(1);
        press_ack = 1'b0;
        chk("ackrise_valid", {7'b0, press_valid}, 8'h1);
        chk("ackrise_vec_l", {4'b0, press_vec}, 8'h2);
        chk("ackrise_ovf", {7'b0, overflow}, 8'h0);
        ack_once();
        release_all();

        // enable gating
        enable  = 1'b0;
        btn_raw = 4'b1000;
        tick(8);
        chk("gate_level", {4'b0, btn_level}, 8'h8);
        chk("gate_valid_off", {7'b0, press_valid}, 8'h0);
        enable = 1'b1;
        tick(3);
        chk("gate_valid_held", {7'b0, press_valid}, 8'h0);
        release_all();
        btn_raw = 4'b1000;
        exp_q.push_back(4'b1000);
        tick(6);
        chk("gate_repress_valid", {7'b0, press_valid}, 8'h1);
        chk("gate_repress_vec", {4'b0, press_vec}, 8'h8);
        enable = 1'b0;
        tick(1);
        chk("gate_drop_valid", {7'b0, press_valid}, 8'h0);
        chk("gate_drop_vec", {4'b0, press_vec}, 8'h0);
        enable = 1'b1;
        release_all();

        // async reset mid-count with an event pending
        btn_raw = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(6);
        chk("areset_pending", {7'b0, press_valid}, 8'h1);
        btn_raw = 4'b0011;
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_level", {4'b0, btn_level}, 8'h0);
        chk("areset_valid", {7'b0, press_valid}, 8'h0);
        chk("areset_vec", {4'b0, press_vec}, 8'h0);
        chk("areset_pulse", {4'b0, press_pulse}, 8'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(4'b0011);
        tick(5);
        chk("areset_level_early", {4'b0, btn_level}, 8'h0);
        tick(1);
        chk("areset_level_back", {4'b0, btn_level}, 8'h3);
        chk("areset_vec_back", {4'b0, press_vec}, 8'h3);
        ack_once();
        release_all();

        chk("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
